// File: rtl/count_extender.sv
// Extends a 3-bit up/down counter into an (EXT_W+3)-bit position by tracking wraps and flagging illegal steps.
// Latency: one cycle from y to pos; no backpressure, y is sampled on every edge.
module count_extender #(
    parameter int EXT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       y,
    input  logic             clr_err,
    output logic [EXT_W+2:0] pos,
    output logic             valid,
    output logic             wrap_up,
    output logic             wrap_dn,
    output logic             step_err
);

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       low_q, low_d;
    logic [EXT_W-1:0] upper_q, upper_d;
    logic             wrap_up_q, wrap_up_d;
    logic             wrap_dn_q, wrap_dn_d;
    logic             step_err_q, step_err_d;
    logic [2:0]       delta;

    always_comb begin
        state_d    = state_q;
        low_d      = low_q;
        upper_d    = upper_q;
        wrap_up_d  = 1'b0;
        wrap_dn_d  = 1'b0;
        step_err_d = step_err_q;
        // 3-bit subtraction gives the step modulo 8 directly
        delta      = y - low_q;

        case (state_q)
            ST_INIT: begin
                low_d      = y;
                upper_d    = '0;
                step_err_d = 1'b0;
                state_d    = ST_TRACK;
            end
            ST_TRACK: begin
                if (clr_err) begin
                    step_err_d = 1'b0;
                end
                low_d = y;
                case (delta)
                    3'd0: begin
                        low_d = low_q;
                    end
                    3'd1: begin
                        if (low_q == 3'd7) begin
                            upper_d   = upper_q + EXT_W'(1);
                            wrap_up_d = 1'b1;
                        end
                    end
                    3'd7: begin
                        if (low_q == 3'd0) begin
                            upper_d   = upper_q - EXT_W'(1);
                            wrap_dn_d = 1'b1;
                        end
                    end
                    default: begin
                        // illegal jump: resync low, keep upper, set wins over clr_err
                        step_err_d = 1'b1;
                    end
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_INIT;
            low_q      <= 3'd0;
            upper_q    <= '0;
            wrap_up_q  <= 1'b0;
            wrap_dn_q  <= 1'b0;
            step_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            low_q      <= low_d;
            upper_q    <= upper_d;
            wrap_up_q  <= wrap_up_d;
            wrap_dn_q  <= wrap_dn_d;
            step_err_q <= step_err_d;
        end
    end

    assign pos      = {upper_q, low_q};
    assign valid    = (state_q == ST_TRACK);
    assign wrap_up  = wrap_up_q;
    assign wrap_dn  = wrap_dn_q;
    assign step_err = step_err_q;

endmodule
